apb_master_mslv: RTL
====================

Name: apb_master_mslv

Overview:
- Parametrised APB master that replaces the fixed 8-bit, single-slave master.
- Accepts one command at a time over a valid/ready request interface, decodes the target slave from the upper address bits and drives one of NSLV PSEL lines.
- Runs the IDLE/SETUP/ACCESS protocol with PREADY wait states, PSTRB and PSLVERR, and returns a one-cycle response pulse carrying read data and error status.
- Sits between the on-chip command source and the APB slave fabric.

Parameters:
- AW, 16, address width (bits).
- DW, 32, data width; must be a multiple of 8.
- NSLV, 4, number of APB slaves, 1..16.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock; everything is rising-edge.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AW  byte address.
- cmd_wdata  in  DW  write data.
- cmd_strb  in  DW/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DW  read data.
- rsp_err  out  1  slave/decode/timeout error.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pstrb  out  DW/8  APB strobes.
- prdata  in  NSLV*DW  read data; slave i occupies bits [i*DW +: DW].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

Behaviour:
- Reset: all outputs are registered and clear to 0 asynchronously on presetn low. State goes to IDLE; cmd_ready rises after reset release.
- SW = clog2(NSLV), or 0 when NSLV=1. Slave index = cmd_addr[AW-1 -: SW]; index is 0 when SW=0.
- FSM states are IDLE, SETUP and ACCESS. cmd_ready = (state==IDLE).
- IDLE, cmd_valid&cmd_ready, index<NSLV:
  - Latch paddr=cmd_addr, pwrite=cmd_write and index.
  - pwdata=cmd_wdata and pstrb=cmd_strb on writes; pwdata=0 and pstrb=0 on reads.
  - Set psel[index]=1 and go to SETUP.
- IDLE, accepted command with index>=NSLV (decode error):
  - No APB activity and state stays IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- SETUP: psel held, penable=0. Unconditionally go to ACCESS with penable=1.
- ACCESS: only pready[index], pslverr[index] and prdata slice [index] are sampled; other slaves' signals are ignored.
  - pready[index]=0: stay in ACCESS and hold all APB outputs stable.
  - pready[index]=1: go to IDLE and clear psel/penable.
  - On that same edge, register rsp_valid=1 and rsp_err=pslverr[index].
  - rsp_rdata = selected prdata slice on reads (passed through even when rsp_err=1); rsp_rdata=0 on writes.
- Latency: accept edge E0, SETUP after E0, ACCESS after E1. With zero wait states, rsp_valid is high in the cycle after E2. Each wait state adds one cycle.
- rsp_valid is high for exactly one cycle; there is no backpressure. rsp_rdata/rsp_err hold their value until the next response.
- A new command may be accepted in the same cycle rsp_valid is high. Back-to-back transfers therefore have one IDLE cycle between ACCESS and the next SETUP.
- paddr/pwrite/pwdata/pstrb hold their last values in IDLE; only psel/penable return to 0.
- Reset mid-transfer: psel/penable/rsp_valid drop immediately. The command is dropped and no response is issued after release.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS edge with pready[index]=0.
  - On the edge where the counter reaches TIMEOUT_CYCLES, the transfer aborts: go to IDLE, clear psel/penable, set rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - If pready[index]=1 on that same edge, normal completion wins.
- Not defined: no counter exists; ACCESS waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
1. Write, AW=16, NSLV=4, zero wait: addr 0x4010, wdata 0xA5A55A5A, strb 0xF, pready[1]=1 → psel=0010 for 2 cycles, penable 1 cycle, pstrb=0xF, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
2. Read slave 3, addr 0xC004, pready[3] low 2 ACCESS cycles, prdata slice3=0x12345678 → penable high 3 cycles, pstrb=0, rsp_rdata=0x12345678, rsp_valid 5 cycles after accept.
3. Read slave 0 with pslverr[0]=1 and prdata0=0xDEADBEEF at completion → rsp_err=1, rsp_rdata=0xDEADBEEF. pready/pslverr toggling on slaves 1-3 has no effect.
4. NSLV=3, addr 0xC000 (index 3) → psel stays 000, rsp_valid/rsp_err=1 the next cycle, rsp_rdata=0, cmd_ready stays 1.
5. APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready held 0 → abort on the 8th ACCESS edge, psel cleared, rsp_err=1, rsp_rdata=0. Without the macro, still in ACCESS after 100 cycles.
6. presetn low during ACCESS → outputs 0 in the same cycle, no rsp_valid after release, next write to slave 2 completes normally.

Source files
------------

// File: rtl/apb_master_mslv.sv
// -----------------------------------------------------------------------------
// apb_master_mslv
//
// Parametrised APB master for NSLV slaves. It takes one command at a time over
// a valid/ready interface. It decodes the target slave from the upper address
// bits and runs the IDLE -> SETUP -> ACCESS sequence on the selected PSEL line.
// When the transfer ends it returns a one-cycle response pulse.
//
// Optional feature (macro APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that waits TIMEOUT_CYCLES cycles without
//   pready from the selected slave is aborted. The abort returns an error
//   response. When undefined, ACCESS waits indefinitely.
//
// Parameters:
//   AW             address width
//   DW             data width (multiple of 8)
//   NSLV           number of slaves, 1..16
//   TIMEOUT_CYCLES ACCESS wait limit (APB_TIMEOUT_EN builds only)
//
// Ports:
//   pclk, presetn              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_strb        command payload
//   rsp_valid, rsp_rdata,
//   rsp_err                    one-cycle response; data and error hold until
//                              the next response
//   psel, penable, pwrite,
//   paddr, pwdata, pstrb       APB request side (all registered)
//   prdata, pready, pslverr    APB slave returns; slave i uses slice i
// -----------------------------------------------------------------------------
module apb_master_mslv #(
  parameter int AW             = 16,
  parameter int DW             = 32,
  parameter int NSLV           = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [DW-1:0]        cmd_wdata,
  input  logic [DW/8-1:0]      cmd_strb,
  output logic                 rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [NSLV-1:0]      psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [AW-1:0]        paddr,
  output logic [DW-1:0]        pwdata,
  output logic [DW/8-1:0]      pstrb,
  input  logic [NSLV*DW-1:0]   prdata,
  input  logic [NSLV-1:0]      pready,
  input  logic [NSLV-1:0]      pslverr
);

  // Slave-index width taken from the top of the address. The register width
  // is kept at least one bit so that NSLV=1 still elaborates.
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 0;
  localparam int IW = (SW > 0) ? SW : 1;
  localparam logic [IW:0] NSLV_W = (IW+1)'(NSLV);

  if ((DW % 8) != 0 || DW < 8) begin : g_bad_dw
    $error("apb_master_mslv: DW must be a non-zero multiple of 8");
  end
  if (NSLV < 1 || NSLV > 16) begin : g_bad_nslv
    $error("apb_master_mslv: NSLV must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_mslv: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;        // slave owning the current transfer
  logic [IW-1:0]   cmd_idx;    // slave addressed by the incoming command
  logic            decode_err;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;

  if (SW == 0) begin : g_single
    assign cmd_idx = '0;
  end else begin : g_decode
    assign cmd_idx = cmd_addr[AW-1 -: SW];
  end

  // Only reachable when NSLV is not a power of two.
  assign decode_err = ({1'b0, cmd_idx} >= NSLV_W);

  // Return mux: only the slave that owns the transfer is looked at.
  always_comb begin
    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == IW'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DW +: DW];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // The counter still holds the previous count on the edge being decided, so
  // the limit is reached when that count is one short of TIMEOUT_CYCLES.
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      idx       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every register here sees the
      // values from before the edge, whatever the statement order.
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (decode_err) begin
              // No slave behind this address: answer at once and stay idle.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= SETUP;
              cmd_ready <= 1'b0;
              idx       <= cmd_idx;
              paddr     <= cmd_addr;
              pwrite    <= cmd_write;
              pwdata    <= cmd_write ? cmd_wdata : '0;
              pstrb     <= cmd_write ? cmd_strb  : '0;
              psel      <= NSLV'(1) << cmd_idx;
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (sel_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            // Read data is passed through even on a slave error.
            rsp_rdata <= pwrite ? '0 : sel_rdata;
          end
`ifdef APB_TIMEOUT_EN
          else if (timeout_hit) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        default: begin
          state     <= IDLE;
          psel      <= '0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule
